// File: rtl/bin_to_digits.sv
// bin_to_digits: splits a 6-bit binary value into tens and ones BCD digits
// by repeated subtraction of 10, then offers the two digits (tens first)
// on a valid/ready stream. The last completed result is also kept on
// Tens_Out/Ones_Out.
module bin_to_digits (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start_In,
   input  logic [5:0] Bin_In,
   output logic       Busy_Out,
   output logic [3:0] Digit_Out,
   output logic       Digit_Valid_Out,
   input  logic       Digit_Ready_In,
   output logic       Digit_Last_Out,
   output logic [3:0] Tens_Out,
   output logic [3:0] Ones_Out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIV    = 2'd1,
      EMIT_T = 2'd2,
      EMIT_O = 2'd3
   } state_t;

   localparam logic [5:0] TEN = 6'd10;

   state_t     state;
   logic [5:0] remainder;
   logic [3:0] tens_cnt;

   // Conversion FSM. Every output is a register updated together with the
   // state, so Digit_Valid_Out never depends combinationally on
   // Digit_Ready_In and the offered digit stays frozen during stalls.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state           <= IDLE;
         remainder       <= '0;
         tens_cnt        <= '0;
         Busy_Out        <= 1'b0;
         Digit_Out       <= '0;
         Digit_Valid_Out <= 1'b0;
         Digit_Last_Out  <= 1'b0;
         Tens_Out        <= '0;
         Ones_Out        <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Start is only looked at here, so a request that arrives
               // during a conversion or its final handshake is dropped.
               if (Start_In) begin
                  remainder <= Bin_In;
                  tens_cnt  <= '0;
                  Busy_Out  <= 1'b1;
                  state     <= DIV;
               end
            end
            DIV: begin
               if (remainder >= TEN) begin
                  remainder <= remainder - TEN;
                  tens_cnt  <= tens_cnt + 4'd1;
               end else begin
                  // Remainder below 10 is the ones digit; publish the
                  // result and put the tens digit on the stream.
                  Tens_Out        <= tens_cnt;
                  Ones_Out        <= remainder[3:0];
                  Digit_Out       <= tens_cnt;
                  Digit_Last_Out  <= 1'b0;
                  Digit_Valid_Out <= 1'b1;
                  state           <= EMIT_T;
               end
            end
            EMIT_T: begin
               if (Digit_Valid_Out && Digit_Ready_In) begin
                  Digit_Out      <= Ones_Out;
                  Digit_Last_Out <= 1'b1;
                  state          <= EMIT_O;
               end
            end
            EMIT_O: begin
               if (Digit_Valid_Out && Digit_Ready_In) begin
                  Digit_Out       <= '0;
                  Digit_Last_Out  <= 1'b0;
                  Digit_Valid_Out <= 1'b0;
                  Busy_Out        <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: begin
               state           <= IDLE;
               Busy_Out        <= 1'b0;
               Digit_Out       <= '0;
               Digit_Valid_Out <= 1'b0;
               Digit_Last_Out  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_digits.sv
// Testbench for bin_to_digits: directed scenarios plus randomized
// conversions, with a scoreboard queue filled by the stimulus and drained
// by an independent stream monitor.
module tb_bin_to_digits;

   logic       Clk;
   logic       Reset;
   logic       Start_In;
   logic [5:0] Bin_In;
   logic       Busy_Out;
   logic [3:0] Digit_Out;
   logic       Digit_Valid_Out;
   logic       Digit_Ready_In;
   logic       Digit_Last_Out;
   logic [3:0] Tens_Out;
   logic [3:0] Ones_Out;

   bin_to_digits dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Start_In       (Start_In),
      .Bin_In         (Bin_In),
      .Busy_Out       (Busy_Out),
      .Digit_Out      (Digit_Out),
      .Digit_Valid_Out(Digit_Valid_Out),
      .Digit_Ready_In (Digit_Ready_In),
      .Digit_Last_Out (Digit_Last_Out),
      .Tens_Out       (Tens_Out),
      .Ones_Out       (Ones_Out)
   );

   typedef struct {
      logic [3:0] digit;
      logic       last;
      logic [3:0] tens;
      logic [3:0] ones;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;
   int   cyc    = 0;
   int   start_cyc = 0;
   int   ready_mode = 0;   // 0: always ready, 1: random, 2: manual
   logic ready_manual = 1'b1;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
   endtask

   // Reference model: plain decimal division of the requested value.
   task automatic push_expect(input int v);
      exp_t e;
      e.tens  = 4'(v / 10);
      e.ones  = 4'(v % 10);
      e.digit = e.tens;
      e.last  = 1'b0;
      sb.push_back(e);
      e.digit = e.ones;
      e.last  = 1'b1;
      sb.push_back(e);
   endtask

   // Ready driver: single owner of Digit_Ready_In.
   initial begin
      Digit_Ready_In = 1'b0;
      forever begin
         @(posedge Clk);
         #1;
         if (ready_mode == 0)      Digit_Ready_In = 1'b1;
         else if (ready_mode == 1) Digit_Ready_In = 1'($urandom_range(0, 1));
         else                      Digit_Ready_In = ready_manual;
      end
   end

   // Stream monitor: compares each handshake against the scoreboard and
   // checks stall stability and idle-output values.
   initial begin
      logic       prev_stall;
      logic [3:0] prev_digit;
      logic       prev_last;
      exp_t       e;
      prev_stall = 1'b0;
      prev_digit = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid_held", int'(Digit_Valid_Out), 1);
               check("stall_digit_held", int'(Digit_Out), int'(prev_digit));
               check("stall_last_held", int'(Digit_Last_Out), int'(prev_last));
            end
            if (Digit_Valid_Out) begin
               check("busy_while_valid", int'(Busy_Out), 1);
               if (sb.size() == 0) begin
                  check("unexpected_valid", 1, 0);
               end else if (Digit_Ready_In) begin
                  e = sb.pop_front();
                  check("digit", int'(Digit_Out), int'(e.digit));
                  check("digit_last", int'(Digit_Last_Out), int'(e.last));
                  check("tens_out", int'(Tens_Out), int'(e.tens));
                  check("ones_out", int'(Ones_Out), int'(e.ones));
               end
            end else if (!Busy_Out) begin
               check("idle_digit_zero", int'(Digit_Out), 0);
               check("idle_last_zero", int'(Digit_Last_Out), 0);
            end
            prev_stall = Digit_Valid_Out && !Digit_Ready_In;
            prev_digit = Digit_Out;
            prev_last  = Digit_Last_Out;
         end
      end
   end

   // Caller sits at posedge+#1 with the DUT idle; start is accepted on the
   // next edge.
   task automatic issue(input int v);
      Start_In = 1'b1;
      Bin_In   = 6'(v);
      push_expect(v);
      @(posedge Clk);
      #1;
      start_cyc = cyc;
      Start_In  = 1'b0;
      check("busy_after_start", int'(Busy_Out), 1);
   endtask

   task automatic wait_valid(input int v);
      int n;
      n = 0;
      while (!Digit_Valid_Out && n < 40) begin
         @(posedge Clk);
         #1;
         n++;
      end
      check("valid_seen", int'(Digit_Valid_Out), 1);
      check("valid_latency", cyc - start_cyc, v / 10 + 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (Busy_Out && n < 400) begin
         @(posedge Clk);
         #1;
         n++;
      end
      check("idle_reached", int'(Busy_Out), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, int'(Busy_Out), 0);
      check({tag, "_valid"}, int'(Digit_Valid_Out), 0);
      check({tag, "_last"}, int'(Digit_Last_Out), 0);
      check({tag, "_digit"}, int'(Digit_Out), 0);
      check({tag, "_tens"}, int'(Tens_Out), 0);
      check({tag, "_ones"}, int'(Ones_Out), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int v;
      Reset    = 1'b1;
      Start_In = 1'b0;
      Bin_In   = '0;
      #2;
      check_all_zero("reset");
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b0;

      // Zero value, always ready.
      issue(0);
      wait_valid(0);
      wait_idle();
      // Largest value.
      issue(63);
      wait_valid(63);
      wait_idle();

      // Consumer stalls for 5 cycles on the tens digit.
      ready_mode   = 2;
      ready_manual = 1'b0;
      @(posedge Clk);
      #1;
      issue(37);
      wait_valid(37);
      repeat (5) begin
         @(posedge Clk);
         #1;
         check("stall37_digit", int'(Digit_Out), 3);
      end
      ready_manual = 1'b1;
      wait_idle();
      ready_mode = 0;

      // Start pulsed during DIV is ignored.
      @(posedge Clk);
      #1;
      issue(21);
      Start_In = 1'b1;
      Bin_In   = 6'd50;
      @(posedge Clk);
      #1;
      Start_In = 1'b0;
      wait_valid(21);
      wait_idle();
      repeat (3) @(posedge Clk);
      #1;
      check("ignored_start_busy", int'(Busy_Out), 0);

      // Reset mid-DIV discards the conversion and the old result.
      issue(12);
      wait_valid(12);
      wait_idle();
      @(posedge Clk);
      #1;
      issue(45);
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      #1;
      check_all_zero("midreset");
      sb.delete();
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      issue(9);
      wait_valid(9);
      wait_idle();

      // Back-to-back with Start held high.
      @(posedge Clk);
      #1;
      issue(10);
      Start_In = 1'b1;
      Bin_In   = 6'd9;
      push_expect(9);
      begin
         int n;
         n = 0;
         while (Busy_Out && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
         end
         check("b2b_first_done", int'(Busy_Out), 0);
         @(posedge Clk);
         #1;
         check("b2b_restart", int'(Busy_Out), 1);
         Start_In = 1'b0;
      end
      wait_idle();

      // Randomized conversions with random back-pressure.
      ready_mode = 1;
      for (int i = 0; i < 30; i++) begin
         @(posedge Clk);
         #1;
         v = int'($urandom_range(0, 63));
         issue(v);
         wait_valid(v);
         wait_idle();
      end
      ready_mode = 0;
      repeat (4) @(posedge Clk);
      #1;
      check("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
